// File: rtl/bus_burst_slave_ram.sv
// Burst slave RAM answering the CI DMA master: first read beat 2 cycles after begin,
// write beats land in 1 cycle. Optional write-phase stall injection under `BUSY_INJECT_EN.
module bus_burst_slave_ram #(
  parameter logic [31:0] BASE_ADDR = 32'h5000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          ADDR_W    = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_beginTransaction,
  input  logic        in_endTransaction,
  input  logic        in_readNotWrite,
  input  logic [31:0] in_addressData,
  input  logic [3:0]  in_byteEnable,
  input  logic [7:0]  in_burstSize,
  input  logic        in_dataValid,
  input  logic        in_busy,
  output logic [31:0] out_addressData,
  output logic        out_dataValid,
  output logic        out_endTransaction,
  output logic        out_busy,
  output logic        out_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_PREP,
    S_READ,
    S_READ_END
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [8:0]        beats_q, beats_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [3:0]        be_q, be_d;
  logic              err_q, err_d;
  logic              wr_en;
  logic              hit;
  logic [31:0]       rd_data_q;
  logic [31:0]       mem [DEPTH];

  // The window is DEPTH*4-aligned, so a hit is just an upper-bit match.
  assign hit = (in_addressData[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);

`ifdef BUSY_INJECT_EN
  logic [1:0] bcnt_q, bcnt_d;

  assign out_busy = (state_q == S_WRITE) && (bcnt_q == 2'd3);

  always_comb begin
    bcnt_d = 2'd0;
    if (state_q == S_WRITE) bcnt_d = bcnt_q + 2'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) bcnt_q <= 2'd0;
    else        bcnt_q <= bcnt_d;
  end
`else
  assign out_busy = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
    be_d    = be_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_beginTransaction) begin
          if (hit) begin
            ptr_d   = in_addressData[ADDR_W+1:2];
            beats_d = {1'b0, in_burstSize} + 9'd1;
            cnt_d   = 9'd0;
            be_d    = in_byteEnable;
            state_d = in_readNotWrite ? S_READ_PREP : S_WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        // Surplus beats past the burst length are silently dropped.
        if (in_dataValid && !out_busy && (cnt_q != beats_q)) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + ADDR_W'(1);
          cnt_d = cnt_q + 9'd1;
        end
        if (in_endTransaction) state_d = S_IDLE;
      end
      S_READ_PREP: state_d = S_READ;
      S_READ: begin
        if (in_endTransaction) begin
          state_d = S_IDLE;
        end else if (!in_busy) begin
          ptr_d = ptr_q + ADDR_W'(1);
          cnt_d = cnt_q + 9'd1;
          if ((cnt_q + 9'd1) == beats_q) state_d = S_READ_END;
        end
      end
      S_READ_END: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      beats_q <= 9'd0;
      cnt_q   <= 9'd0;
      be_q    <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
      be_q    <= be_d;
      err_q   <= err_d;
    end
  end

  // Reading at ptr_d keeps the registered word aligned with ptr_q, and re-reads it while stalled.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[ptr_q][8*b +: 8] <= in_addressData[8*b +: 8];
      end
    end
    rd_data_q <= mem[ptr_d];
  end

  assign out_dataValid      = (state_q == S_READ);
  assign out_addressData    = (state_q == S_READ) ? rd_data_q : 32'd0;
  assign out_endTransaction = (state_q == S_READ_END);
  assign out_error          = err_q;

endmodule

// File: tb/tb_bus_burst_slave_ram.sv
// Directed and randomized bursts against bus_burst_slave_ram, checked against an array model.
`timescale 1ns/1ps
module tb_bus_burst_slave_ram;

  localparam logic [31:0] BASE  = 32'h5000_0000;
  localparam int          DEPTH = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_beginTransaction = 1'b0;
  logic        in_endTransaction = 1'b0;
  logic        in_readNotWrite = 1'b0;
  logic [31:0] in_addressData = 32'd0;
  logic [3:0]  in_byteEnable = 4'd0;
  logic [7:0]  in_burstSize = 8'd0;
  logic        in_dataValid = 1'b0;
  logic        in_busy = 1'b0;
  logic [31:0] out_addressData;
  logic        out_dataValid;
  logic        out_endTransaction;
  logic        out_busy;
  logic        out_error;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] first_dat;

  always #5 clock = ~clock;

  bus_burst_slave_ram dut (
    .clock              (clock),
    .reset              (reset),
    .in_beginTransaction(in_beginTransaction),
    .in_endTransaction  (in_endTransaction),
    .in_readNotWrite    (in_readNotWrite),
    .in_addressData     (in_addressData),
    .in_byteEnable      (in_byteEnable),
    .in_burstSize       (in_burstSize),
    .in_dataValid       (in_dataValid),
    .in_busy            (in_busy),
    .out_addressData    (out_addressData),
    .out_dataValid      (out_dataValid),
    .out_endTransaction (out_endTransaction),
    .out_busy           (out_busy),
    .out_error          (out_error)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_dat"}, out_addressData, 32'd0);
    chk({tag, "_vld"}, out_dataValid, 1'b0);
    chk({tag, "_end"}, out_endTransaction, 1'b0);
    chk({tag, "_busy"}, out_busy, 1'b0);
    chk({tag, "_err"}, out_error, 1'b0);
  endtask

  // Write burst of nbeats declared, nsend actually presented; model keeps only the first nbeats.
  task automatic do_write(input logic [31:0] addr, input int nbeats, input int nsend,
                          input logic [3:0] be, input logic [31:0] d0, input bit rnd);
    int          w = int'((addr - BASE) >> 2);
    int          i = 0;
    int          guard = 0;
    logic [31:0] vals[$];
    for (int k = 0; k < nsend; k++) vals.push_back(rnd ? $urandom : d0 + 32'(k));
    @(negedge clock);
    in_beginTransaction = 1'b1;
    in_readNotWrite     = 1'b0;
    in_addressData      = addr;
    in_byteEnable       = be;
    in_burstSize        = 8'(nbeats - 1);
    @(negedge clock);
    in_beginTransaction = 1'b0;
    chk("wr_begin_err", out_error, 1'b0);
    while (i < nsend && guard < 100) begin
      in_dataValid      = 1'b1;
      in_addressData    = vals[i];
      in_endTransaction = (i == nsend - 1) && !out_busy;
      if (!out_busy) begin
        if (i < nbeats) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[(w + i) % DEPTH][8*b +: 8] = vals[i][8*b +: 8];
        end
        i++;
      end
      guard++;
      @(negedge clock);
    end
    in_dataValid      = 1'b0;
    in_endTransaction = 1'b0;
    in_addressData    = 32'd0;
    chk("wr_beats_sent", i, nsend);
    chk("wr_no_rd_vld", out_dataValid, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int nbeats, input logic [31:0] busy_mask,
                         input bit rnd_busy, output logic [31:0] first);
    int   w = int'((addr - BASE) >> 2);
    int   got = 0;
    int   cyc = 0;
    logic busy;
    first = 32'hx;
    @(negedge clock);
    in_beginTransaction = 1'b1;
    in_readNotWrite     = 1'b1;
    in_addressData      = addr;
    in_burstSize        = 8'(nbeats - 1);
    @(negedge clock);
    in_beginTransaction = 1'b0;
    in_addressData      = 32'd0;
    chk("rd_prep_vld", out_dataValid, 1'b0);
    @(negedge clock);
    while (got < nbeats && cyc < 200) begin
      chk("rd_vld", out_dataValid, 1'b1);
      chk("rd_dat", out_addressData, ref_mem[(w + got) % DEPTH]);
      chk("rd_err", out_error, 1'b0);
      if (cyc == 0) first = out_addressData;
      busy = rnd_busy ? ($urandom_range(0, 3) == 0) : ((cyc < 32) && busy_mask[cyc]);
      in_busy = busy;
      if (!busy) got++;
      cyc++;
      @(negedge clock);
    end
    in_busy = 1'b0;
    chk("rd_beats", got, nbeats);
    chk("rd_last_vld", out_dataValid, 1'b0);
    chk("rd_end", out_endTransaction, 1'b1);
    @(negedge clock);
    chk("rd_end_clr", out_endTransaction, 1'b0);
  endtask

  task automatic do_miss(input logic [31:0] addr, input string tag);
    @(negedge clock);
    in_beginTransaction = 1'b1;
    in_readNotWrite     = 1'b1;
    in_addressData      = addr;
    in_burstSize        = 8'd3;
    @(negedge clock);
    in_beginTransaction = 1'b0;
    in_addressData      = 32'd0;
    chk({tag, "_err"}, out_error, 1'b1);
    chk({tag, "_vld"}, out_dataValid, 1'b0);
    @(negedge clock);
    chk({tag, "_err_clr"}, out_error, 1'b0);
    chk({tag, "_vld2"}, out_dataValid, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk_outputs_zero("reset");
    reset = 1'b1;
    @(negedge clock);
    chk_outputs_zero("idle");

    // Basic write then read back at BASE+0x10
    do_write(BASE + 32'h10, 4, 4, 4'hF, 32'hA0, 1'b0);
    do_read(BASE + 32'h10, 4, 32'd0, 1'b0, first_dat);
    chk("rd_first_a0", first_dat, 32'hA0);

    // Byte offset within the word is ignored
    do_read(BASE + 32'h13, 2, 32'd0, 1'b0, first_dat);
    chk("rd_offset_a0", first_dat, 32'hA0);

    // Master stall in data-phase cycles 2-3
    do_read(BASE + 32'h10, 4, 32'b0110, 1'b0, first_dat);

    // Wrap across the top of the window, both directions
    do_write(BASE + 32'(DEPTH - 2) * 4, 4, 4, 4'hF, 32'h0, 1'b1);
    do_read(BASE + 32'(DEPTH - 2) * 4, 4, 32'd0, 1'b0, first_dat);

    // Out-of-window begins
    do_miss(BASE - 32'd4, "miss_lo");
    do_miss(BASE + 32'(DEPTH) * 4, "miss_hi");

    // Partial byte enables merge with the existing word
    do_write(BASE + 32'd800, 1, 1, 4'hF, 32'h1234_5678, 1'b0);
    do_write(BASE + 32'd800, 1, 1, 4'b0011, 32'hFFFF_FFFF, 1'b0);
    do_read(BASE + 32'd800, 1, 32'd0, 1'b0, first_dat);
    chk("be_merge", first_dat, 32'h1234_FFFF);

    // Surplus write beats beyond the burst length are dropped
    do_write(BASE + 32'd400, 4, 4, 4'hF, 32'h5500, 1'b0);
    do_write(BASE + 32'd400, 2, 4, 4'hF, 32'h6600, 1'b0);
    do_read(BASE + 32'd400, 4, 32'd0, 1'b0, first_dat);

    // Background region for randomized traffic
    do_write(BASE, 64, 64, 4'hF, 32'h0, 1'b1);

    // Abort a read with in_endTransaction after two beats
    @(negedge clock);
    in_beginTransaction = 1'b1;
    in_readNotWrite     = 1'b1;
    in_addressData      = BASE;
    in_burstSize        = 8'd7;
    @(negedge clock);
    in_beginTransaction = 1'b0;
    in_addressData      = 32'd0;
    @(negedge clock);
    chk("abort_b0", out_addressData, ref_mem[0]);
    @(negedge clock);
    chk("abort_b1", out_addressData, ref_mem[1]);
    in_endTransaction = 1'b1;
    @(negedge clock);
    in_endTransaction = 1'b0;
    chk("abort_vld", out_dataValid, 1'b0);
    chk("abort_end", out_endTransaction, 1'b0);
    @(negedge clock);
    chk("abort_end2", out_endTransaction, 1'b0);
    do_read(BASE + 32'd8, 3, 32'd0, 1'b0, first_dat);

    // Asynchronous reset in the middle of a read burst
    @(negedge clock);
    in_beginTransaction = 1'b1;
    in_readNotWrite     = 1'b1;
    in_addressData      = BASE;
    in_burstSize        = 8'd7;
    @(negedge clock);
    in_beginTransaction = 1'b0;
    in_addressData      = 32'd0;
    @(negedge clock);
    chk("rst_pre_vld", out_dataValid, 1'b1);
    #2 reset = 1'b0;
    #1 chk_outputs_zero("rst_mid");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_outputs_zero("rst_after");
    do_read(BASE + 32'h10, 4, 32'd0, 1'b0, first_dat);

    // Randomized mixed traffic inside the background region
    for (int t = 0; t < 24; t++) begin
      int          w = $urandom_range(0, 56);
      int          n = $urandom_range(1, 8);
      logic [31:0] a = BASE + 32'(w) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, n, n, 4'($urandom_range(1, 15)), 32'h0, 1'b1);
      else
        do_read(a, n, 32'd0, 1'b1, first_dat);
    end
    do_read(BASE, 64, 32'd0, 1'b1, first_dat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
